tipi_rpi_link: RTL and testbench
================================

# tipi_rpi_link

Clocked serial-link master that drives the RPi-side shift interface of the TIPI CPLD (r_clk, r_le, r_rt, r_dc, r_dout, r_din). It sits directly upstream of the CPLD's RD/RC shift-in registers and TD/TC load-and-shift-out registers. It turns single-byte command/response transactions into the bit-serial sequence those registers expect. Host logic issues "write RD/RC" or "read TD/TC" and receives a byte or completion pulse.

## Interface
Parameters:
- CLK_DIV, 4, system clocks per r_clk half-period; legal range 1..255.

Ports:
- clk  in  1  system clock. One clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 = write RD, 01 = write RC, 10 = read TD, 11 = read TC.
- cmd_data  in  [0:7]  write byte; bit 0 is the MSB, following TI convention.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  [0:7]  read byte. Held until the next read completes; 0 after reset.
- abort  out  1  one-cycle pulse when a transfer is killed by a TI reset request.
- ti_reset_req  in  1  asynchronous CRU reset bit from the CPLD (r_reset).
- r_clk, r_le, r_rt, r_dc, r_dout  out  1 each  serial link to the CPLD.
- r_din  in  1  serial data from the CPLD.

## Operation
- Register selection encoding:
  - r_rt = cmd_op[0] (0 = RPi-originated RD/RC, 1 = TI-originated TD/TC).
  - r_dc = cmd_op[1] (0 = data, 1 = control).
- On accept, latch cmd_op and cmd_data, then drive r_rt/r_dc. Both hold stable until rsp_valid.
- States: IDLE, SETUP, LOAD_HI, LOAD_LO, BIT_LO, BIT_HI, LATCH_HI, LATCH_LO, DONE. Every state except IDLE and DONE lasts exactly CLK_DIV cycles, timed by a tick counter.
- Write (op 00/01):
  - Sequence: SETUP → 8 × (BIT_LO, BIT_HI) → LATCH_HI → LATCH_LO → DONE.
  - In BIT_LO, r_dout is set to bit n, MSB first (cmd_data[0] first). r_clk = 1 in BIT_HI.
  - In LATCH_HI, r_le = 1; LATCH_LO returns it to 0.
- Read (op 10/11):
  - Sequence: SETUP → LOAD_HI (r_le = 1, parallel load) → LOAD_LO → 8 × (BIT_LO, BIT_HI) → DONE.
  - r_din is sampled on the last cycle of each BIT_LO, before the rising r_clk edge, and shifted into position 0 first.
  - rsp_data updates in DONE.
- DONE: rsp_valid = 1 for one cycle, then IDLE.
- r_dout is 0 outside write BIT phases. r_clk and r_le are 0 except in their HI states.
- ti_reset_req passes through a 2-flop synchronizer (reset to 0).
  - While the synchronized value is 1, the block is forced to IDLE and cmd_ready = 0.
  - If the block was not in IDLE when the synchronized value rose, abort pulses for one cycle and no rsp_valid is issued.
  - rsp_data is unchanged.
- cmd_valid while busy is ignored. No queuing.

## Timing
- Reset values:
  - cmd_ready = 1; rsp_valid = 0; rsp_data = 0x00; abort = 0.
  - r_clk = r_le = r_rt = r_dc = r_dout = 0.
  - Synchronizer = 0; state = IDLE.
- Reset asserted mid-transfer returns all outputs to reset values immediately (asynchronously). No rsp_valid or abort is generated for that transfer.
- Latency from accept edge to rsp_valid, for both write and read: 19·CLK_DIV + 1 cycles.
  - Breakdown: SETUP D, LE pulse 2D, 8 bits 16D, plus one DONE cycle.
- Throughput: the next command can be accepted on the cycle after DONE (IDLE), i.e. 19·CLK_DIV + 2 cycles per transaction.
- The tick counter is 8 bits. It reloads to CLK_DIV−1 on every state entry and wraps at 0 into the next state.
- The bit counter is 3 bits. Exit from the bit loop is on count 7 at the end of BIT_HI.
- Abort takes effect 2 cycles after ti_reset_req rises, due to the synchronizer.

## Structure
- Shared package tipi_link_pkg: cmd_op encodings (OP_WR_RD, OP_WR_RC, OP_RD_TD, OP_RD_TC) and state enumeration constants.
- One sub-module, tipi_link_sync: a 2-flop synchronizer with async active-high reset, used for ti_reset_req.
- The FSM, tick counter, bit counter and shift register live in tipi_rpi_link.

## Test plan
- CLK_DIV = 2, write RD 0xA5:
  - r_rt = 0, r_dc = 0.
  - r_dout at the 8 r_clk rising edges = 1,0,1,0,0,1,0,1.
  - One r_le pulse after the 8th edge.
  - rsp_valid 39 cycles after accept.
  - A CPLD behavioural model holds RD = 0xA5.
- CLK_DIV = 2, read TC with the model's TC = 0x3C:
  - r_rt = 1, r_dc = 1.
  - r_le pulse precedes the first r_clk.
  - rsp_data = 0x3C with rsp_valid.
- Back-to-back write RC 0x01 then read TD 0xFF with cmd_valid held high:
  - Second accept occurs on the cycle after the first rsp_valid.
  - cmd_ready = 0 throughout each transfer.
- Assert reset during the 4th bit of a write:
  - All r_* outputs go to 0 immediately; cmd_ready = 1.
  - No rsp_valid.
  - A following write of 0x5A completes normally.
- Raise ti_reset_req mid-read:
  - abort pulses once 2 cycles later; no rsp_valid.
  - rsp_data keeps its previous value.
  - cmd_ready stays 0 until ti_reset_req is low and synchronized.
- CLK_DIV = 1 and CLK_DIV = 255, write/read loopback of 0x80 and 0x01: bit order and latencies of 20 and 4846 cycles are confirmed.

Source files
------------

// File: rtl/tipi_link_pkg.sv
// Shared definitions for the TIPI RPi-side serial link: command opcodes and
// the link master's state enumeration.
package tipi_link_pkg;

  localparam logic [1:0] OP_WR_RD = 2'b00;
  localparam logic [1:0] OP_WR_RC = 2'b01;
  localparam logic [1:0] OP_RD_TD = 2'b10;
  localparam logic [1:0] OP_RD_TC = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD_HI,
    ST_LOAD_LO,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_LATCH_HI,
    ST_LATCH_LO,
    ST_DONE
  } link_state_t;

  // Left opcode bit selects the TI-originated (read) registers.
  function automatic logic op_is_read(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/tipi_link_sync.sv
// Two-flop synchronizer for an asynchronous level input, cleared by reset.
module tipi_link_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tipi_rpi_link.sv
// Serial-link master driving the TIPI CPLD shift interface: one byte per
// command, written into RD/RC or read back from TD/TC, MSB (bit 0) first.
module tipi_rpi_link
  import tipi_link_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [0:1] cmd_op,
  input  logic [0:7] cmd_data,
  output logic       rsp_valid,
  output logic [0:7] rsp_data,
  output logic       abort,
  input  logic       ti_reset_req,
  output logic       r_clk,
  output logic       r_le,
  output logic       r_rt,
  output logic       r_dc,
  output logic       r_dout,
  input  logic       r_din
);

  localparam logic [7:0] TICK_RELOAD = 8'(CLK_DIV - 1);

  link_state_t state, state_nx;
  logic [7:0]  tick;
  logic [2:0]  bit_cnt;
  logic [1:0]  op_q;
  logic [7:0]  data_q;
  logic [7:0]  shift_q;
  logic [7:0]  rsp_q;
  logic        sync_rst;
  logic        tick_end;
  logic        is_read;

  tipi_link_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ti_reset_req),
    .q     (sync_rst)
  );

  assign tick_end = (tick == '0);
  assign is_read  = op_is_read(op_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      tick    <= TICK_RELOAD;
      bit_cnt <= '0;
      op_q    <= '0;
      data_q  <= '0;
      shift_q <= '0;
      rsp_q   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state) begin
        tick <= TICK_RELOAD;
      end else if (state != ST_IDLE) begin
        tick <= tick - 8'd1;
      end
      if (state == ST_IDLE && cmd_valid && !sync_rst) begin
        op_q    <= cmd_op;
        data_q  <= cmd_data;
        bit_cnt <= '0;
      end
      if (state == ST_BIT_HI && tick_end) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      // Sample just before r_clk rises; first bit ends up as the MSB.
      if (state == ST_BIT_LO && tick_end && is_read) begin
        shift_q <= {shift_q[6:0], r_din};
      end
      if (state == ST_DONE && is_read && !sync_rst) begin
        rsp_q <= shift_q;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    abort     = 1'b0;
    r_clk     = 1'b0;
    r_le      = 1'b0;
    r_rt      = 1'b0;
    r_dc      = 1'b0;
    r_dout    = 1'b0;
    rsp_data  = rsp_q;

    case (state)
      ST_IDLE:     if (cmd_valid) state_nx = ST_SETUP;
      ST_SETUP:    if (tick_end) state_nx = is_read ? ST_LOAD_HI : ST_BIT_LO;
      ST_LOAD_HI:  if (tick_end) state_nx = ST_LOAD_LO;
      ST_LOAD_LO:  if (tick_end) state_nx = ST_BIT_LO;
      ST_BIT_LO:   if (tick_end) state_nx = ST_BIT_HI;
      ST_BIT_HI: begin
        if (tick_end) begin
          if (bit_cnt == 3'd7) begin
            state_nx = is_read ? ST_DONE : ST_LATCH_HI;
          end else begin
            state_nx = ST_BIT_LO;
          end
        end
      end
      ST_LATCH_HI: if (tick_end) state_nx = ST_LATCH_LO;
      ST_LATCH_LO: if (tick_end) state_nx = ST_DONE;
      ST_DONE:     state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase

    // A synchronized TI reset overrides everything and quiets the link at once.
    if (sync_rst) begin
      state_nx = ST_IDLE;
      abort    = (state != ST_IDLE);
    end else begin
      cmd_ready = (state == ST_IDLE);
      if (state != ST_IDLE) begin
        r_rt = op_q[1];
        r_dc = op_q[0];
      end
      r_clk = (state == ST_BIT_HI);
      r_le  = (state == ST_LOAD_HI) || (state == ST_LATCH_HI);
      if (!is_read && (state == ST_BIT_LO || state == ST_BIT_HI)) begin
        r_dout = data_q[3'd7 - bit_cnt];
      end
      if (state == ST_DONE) begin
        rsp_valid = 1'b1;
        if (is_read) rsp_data = shift_q;
      end
    end
  end

endmodule

// File: tb/tb_tipi_rpi_link.sv
// Bench for tipi_rpi_link at CLK_DIV 2, 1 and 255: each instance talks to a
// behavioural CPLD and is checked every cycle against a timeline model.
module tb_tipi_rpi_link;
  import tipi_link_pkg::*;

  localparam int NI = 3;
  localparam int DIVS [NI] = '{2, 1, 255};
  localparam int LATS [NI] = '{39, 20, 4846};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s inst%0d actual=%0h required=%0h (cycle %0d)", name, inst, act, req, cyc);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g
    localparam int D    = DIVS[gi];
    localparam int LAT  = LATS[gi];
    localparam int LAST = 19 * D + 1;

    logic       rst = 1'b1, cmd_valid = 1'b0, ti_req = 1'b0;
    logic [0:1] cmd_op = '0;
    logic [0:7] cmd_data = '0;
    logic       cmd_ready, rsp_valid, abort;
    logic       r_clk, r_le, r_rt, r_dc, r_dout, r_din;
    logic [0:7] rsp_data;
    bit         fin = 1'b0;

    tipi_rpi_link #(.CLK_DIV(D)) dut (
      .clk(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .abort(abort), .ti_reset_req(ti_req),
      .r_clk(r_clk), .r_le(r_le), .r_rt(r_rt), .r_dc(r_dc),
      .r_dout(r_dout), .r_din(r_din)
    );

    // CPLD: RD/RC shift-in registers, TD/TC load-and-shift-out register
    logic [7:0] rd = '0, rc = '0, td = '0, tc = '0, sin = '0, sout = '0;
    always @(posedge r_clk or posedge r_le) begin
      if (r_le) begin
        if (r_rt) sout <= r_dc ? tc : td;
        else if (r_dc) rc <= sin;
        else rd <= sin;
      end else begin
        sin  <= {sin[6:0], r_dout};
        sout <= {sout[6:0], 1'b0};
      end
    end
    assign r_din = sout[7];

    // Timeline model: busy_k = cycles since the accept cycle (0 = not busy)
    int busy_k = 0, m_op = 0, m_data = 0, m_rd = 0;
    logic h1 = 1'b0, h2 = 1'b0;
    logic [7:0] last_rsp = '0;

    always @(negedge clk) begin : cmp
      logic e_ready, e_valid, e_abort, e_clk, e_le, e_rt, e_dc, e_dout;
      logic [7:0] e_rsp;
      int p, b;
      if (rst) begin
        busy_k = 0; h1 = 1'b0; h2 = 1'b0; last_rsp = '0;
      end
      e_ready = 0; e_valid = 0; e_abort = 0; e_clk = 0; e_le = 0;
      e_rt = 0; e_dc = 0; e_dout = 0; e_rsp = last_rsp;
      if (h2) begin
        e_abort = (busy_k != 0);
      end else if (busy_k == 0) begin
        e_ready = 1;
      end else begin
        e_rt = (m_op >= 2);
        e_dc = (m_op % 2) == 1;
        if (busy_k == LAST) begin
          e_valid = 1;
          if (m_op >= 2) e_rsp = m_rd[7:0];
        end else begin
          p = (busy_k - 1) / D;
          if (m_op < 2) begin
            if (p >= 1 && p <= 16) begin
              b      = (p - 1) / 2;
              e_clk  = ((p - 1) % 2) == 1;
              e_dout = ((m_data >> (7 - b)) & 1) == 1;
            end
            e_le = (p == 17);
          end else begin
            e_le = (p == 1);
            if (p >= 3) e_clk = ((p - 3) % 2) == 1;
          end
        end
      end
      check("cmd_ready", gi, cmd_ready, e_ready);
      check("rsp_valid", gi, rsp_valid, e_valid);
      check("abort", gi, abort, e_abort);
      check("r_clk", gi, r_clk, e_clk);
      check("r_le", gi, r_le, e_le);
      check("r_rt", gi, r_rt, e_rt);
      check("r_dc", gi, r_dc, e_dc);
      check("r_dout", gi, r_dout, e_dout);
      check("rsp_data", gi, rsp_data, e_rsp);
      if (!rst) begin
        if (h2) begin
          busy_k = 0;
        end else if (busy_k == LAST) begin
          if (m_op >= 2) last_rsp = m_rd[7:0];
          busy_k = 0;
        end else if (busy_k != 0) begin
          busy_k++;
        end else if (cmd_valid) begin
          busy_k = 1;
          m_op   = int'(cmd_op);
          m_data = int'(cmd_data);
          m_rd   = (cmd_op == OP_RD_TC) ? int'(tc) : int'(td);
        end
        h2 = h1;
        h1 = ti_req;
      end
    end

    task automatic start_cmd(input logic [1:0] op, input logic [7:0] d, output int acc);
      if (!cmd_valid) begin
        @(posedge clk); #1;
      end
      cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
      acc = -1;
      for (int n = 0; n < 4 * LAST + 20; n++) begin
        @(negedge clk);
        if (cmd_ready) begin
          acc = cyc;
          break;
        end
      end
      if (acc < 0) begin
        checks++; failures++;
        $display("FAIL accept_timeout inst%0d actual=none required=accept", gi);
      end
    endtask

    task automatic wait_rsp(output int rspc);
      rspc = -1;
      for (int n = 0; n < LAST + 10; n++) begin
        @(negedge clk);
        if (rsp_valid) begin
          rspc = cyc;
          break;
        end
      end
      if (rspc < 0) begin
        checks++; failures++;
        $display("FAIL rsp_timeout inst%0d actual=none required=rsp_valid", gi);
      end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] d, input bit hold,
                         output int acc, output int rspc);
      start_cmd(op, d, acc);
      if (!hold) begin
        @(posedge clk); #1 cmd_valid = 1'b0;
      end
      wait_rsp(rspc);
    endtask

    initial begin : stim
      int a, r, a2, r2, ac, tr, n_ab, n_rv, n_rand;
      logic [1:0] op;
      logic [7:0] d;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_cmd_ready", gi, cmd_ready, 1'b1);
      check("reset_rsp_data", gi, rsp_data, 8'h00);

      issue(OP_WR_RD, 8'hA5, 1'b0, a, r);
      check("wr_latency", gi, r - a, LAT);
      check("cpld_rd_a5", gi, rd, 8'hA5);

      @(posedge clk); #1 tc = 8'h3C;
      issue(OP_RD_TC, 8'h00, 1'b0, a, r);
      check("rd_latency", gi, r - a, LAT);
      check("rd_tc_3c", gi, rsp_data, 8'h3C);

      @(posedge clk); #1 td = 8'hFF;
      issue(OP_WR_RC, 8'h01, 1'b1, a, r);
      issue(OP_RD_TD, 8'h00, 1'b0, a2, r2);
      check("b2b_accept", gi, a2, r + 1);
      check("b2b_rc_01", gi, rc, 8'h01);
      check("b2b_td_ff", gi, rsp_data, 8'hFF);

      issue(OP_WR_RD, 8'h80, 1'b0, a, r);
      check("lb_rd_80", gi, rd, 8'h80);
      @(posedge clk); #1 td = 8'h80;
      issue(OP_RD_TD, 8'h00, 1'b0, a, r);
      check("lb_read_80", gi, rsp_data, 8'h80);
      issue(OP_WR_RC, 8'h01, 1'b0, a, r);
      check("lb_rc_01", gi, rc, 8'h01);
      @(posedge clk); #1 tc = 8'h01;
      issue(OP_RD_TC, 8'h00, 1'b0, a, r);
      check("lb_read_01", gi, rsp_data, 8'h01);
      check("lb_latency", gi, r - a, LAT);

      // reset during bit 3 of a write to RC of 0x1F (that bit is a 1)
      start_cmd(OP_WR_RC, 8'h1F, a);
      @(posedge clk); #1 cmd_valid = 1'b0;
      repeat (7 * D) @(posedge clk);
      #1;
      check("pre_rst_dout", gi, r_dout, 1'b1);
      check("pre_rst_dc", gi, r_dc, 1'b1);
      rst = 1'b1;
      #1;
      check("rst_r_all", gi, {r_clk, r_le, r_rt, r_dc, r_dout}, 5'b0);
      check("rst_cmd_ready", gi, cmd_ready, 1'b1);
      check("rst_rsp_valid", gi, rsp_valid, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      issue(OP_WR_RD, 8'h5A, 1'b0, a, r);
      check("post_rst_rd_5a", gi, rd, 8'h5A);
      check("post_rst_latency", gi, r - a, LAT);

      // TI reset request in the middle of a read
      @(posedge clk); #1 td = 8'h96;
      issue(OP_RD_TD, 8'h00, 1'b0, a, r);
      check("pre_abort_read", gi, rsp_data, 8'h96);
      @(posedge clk); #1 tc = 8'h69;
      start_cmd(OP_RD_TC, 8'h00, a);
      @(posedge clk); #1 cmd_valid = 1'b0;
      repeat (3 * D + 1) @(posedge clk);
      #1 ti_req = 1'b1;
      tr = cyc; ac = -1; n_ab = 0; n_rv = 0;
      for (int n = 0; n < 8; n++) begin
        @(negedge clk);
        if (abort) begin
          n_ab++;
          if (ac < 0) ac = cyc;
        end
        if (rsp_valid) n_rv++;
      end
      check("abort_delay", gi, ac - tr, 2);
      check("abort_count", gi, n_ab, 1);
      check("abort_no_rsp", gi, n_rv, 0);
      check("abort_rsp_kept", gi, rsp_data, 8'h96);
      check("abort_ready_low", gi, cmd_ready, 1'b0);
      @(posedge clk); #1 ti_req = 1'b0;
      @(negedge clk); check("release_ready_0", gi, cmd_ready, 1'b0);
      @(negedge clk); check("release_ready_1", gi, cmd_ready, 1'b0);
      @(negedge clk); check("release_ready_2", gi, cmd_ready, 1'b1);
      issue(OP_RD_TC, 8'h00, 1'b0, a, r);
      check("post_abort_read", gi, rsp_data, 8'h69);

      n_rand = (D > 100) ? 1 : 25;
      for (int n = 0; n < n_rand; n++) begin
        op = 2'($urandom_range(0, 3));
        d  = 8'($urandom);
        @(posedge clk); #1;
        td = 8'($urandom);
        tc = 8'($urandom);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        issue(op, d, 1'b0, a, r);
        check("rand_latency", gi, r - a, LAT);
        case (op)
          OP_WR_RD: check("rand_rd", gi, rd, d);
          OP_WR_RC: check("rand_rc", gi, rc, d);
          OP_RD_TD: check("rand_td", gi, rsp_data, td);
          default:  check("rand_tc", gi, rsp_data, tc);
        endcase
      end
      fin = 1'b1;
    end
  end

  initial begin : finish_ctl
    for (int n = 0; n < 90000; n++) begin
      @(posedge clk);
      if (g[0].fin && g[1].fin && g[2].fin) break;
    end
    if (!(g[0].fin && g[1].fin && g[2].fin)) begin
      checks++; failures++;
      $display("FAIL global_timeout actual=unfinished required=finished");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
